// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI RAM responder: opcodes, counter sizing and
// the state encoding also used by the framebuffer initiator's state machine.
package qspi_pkg;

  localparam logic [7:0] CMD_RESET_EN   = 8'h66;
  localparam logic [7:0] CMD_RESET      = 8'h99;
  localparam logic [7:0] CMD_WRITE_QUAD = 8'h38;
  localparam logic [7:0] CMD_READ_QUAD  = 8'hEB;

  localparam int ADDR_NIBBLES = 6;
  localparam int CNT_W        = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEAD   = 3'd1,
    ST_CMD    = 3'd2,
    ST_ADDR   = 3'd3,
    ST_DUMMY  = 3'd4,
    ST_READ   = 3'd5,
    ST_WRITE  = 3'd6,
    ST_IGNORE = 3'd7
  } state_e;

endpackage

// File: rtl/qspi_nibble_mem.sv
// DEPTH x 4 storage: synchronous write, asynchronous read, so it maps onto
// distributed RAM.
module qspi_nibble_mem #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [3:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [3:0]        rdata
);

  logic [3:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/qspi_ram_responder.sv
// QSPI RAM responder: decodes serial commands on data_in[0] and serves a
// nibble-wide memory with auto-incrementing addresses, clocked by clk.
module qspi_ram_responder
  import qspi_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int LEAD_CYCLES  = 1,
  parameter int DUMMY_CYCLES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       chip_enable,
  input  logic [3:0] data_in,
  output logic [3:0] data_out,
  output logic [3:0] data_dir,
  output logic       soft_reset,
  output logic       cmd_error,
  output state_e     debug_state
);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [6:0]         cmd_bits;
  logic [ADDR_W-1:0]  addr;
  logic               is_read;
  logic               reset_latch;

  logic [7:0]         cmd_byte;
  logic [ADDR_W-1:0]  addr_shift;
  logic [ADDR_W-1:0]  addr_inc;
  logic [ADDR_W-1:0]  rd_addr;
  logic [3:0]         rd_data;
  logic               mem_we;

  assign cmd_byte    = {cmd_bits, data_in[0]};
  assign addr_shift  = ADDR_W'({addr, data_in});
  assign addr_inc    = addr + ADDR_W'(1);
  assign debug_state = state;

  // READ prefetches the next nibble; the zero-dummy case reads with the last
  // address nibble still on the bus.
  always_comb begin
    rd_addr = addr;
    if (state == ST_READ)      rd_addr = addr_inc;
    else if (state == ST_ADDR) rd_addr = addr_shift;
  end

  assign mem_we = !rst && !chip_enable && (state == ST_WRITE);

  qspi_nibble_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (addr),
    .wdata (data_in),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    soft_reset <= 1'b0;
    cmd_error  <= 1'b0;
    if (rst) begin
      state       <= ST_IDLE;
      data_out    <= 4'h0;
      data_dir    <= 4'h0;
      cnt         <= '0;
      cmd_bits    <= '0;
      addr        <= '0;
      is_read     <= 1'b0;
      reset_latch <= 1'b0;
    end else if (chip_enable) begin
      state    <= ST_IDLE;
      data_dir <= 4'h0;
      cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (LEAD_CYCLES == 0) begin
            cmd_bits <= {6'b0, data_in[0]};
            cnt      <= CNT_W'(1);
            state    <= ST_CMD;
          end else if (LEAD_CYCLES == 1) begin
            cnt   <= '0;
            state <= ST_CMD;
          end else begin
            cnt   <= CNT_W'(1);
            state <= ST_LEAD;
          end
        end
        ST_LEAD: begin
          if (cnt == CNT_W'(LEAD_CYCLES - 1)) begin
            cnt   <= '0;
            state <= ST_CMD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_CMD: begin
          cmd_bits <= cmd_byte[6:0];
          if (cnt == CNT_W'(7)) begin
            cnt         <= '0;
            reset_latch <= 1'b0;
            state       <= ST_IGNORE;
            case (cmd_byte)
              CMD_RESET_EN: reset_latch <= 1'b1;
              CMD_RESET:    soft_reset  <= reset_latch;
              CMD_WRITE_QUAD: begin
                is_read <= 1'b0;
                state   <= ST_ADDR;
              end
              CMD_READ_QUAD: begin
                is_read <= 1'b1;
                state   <= ST_ADDR;
              end
              default:      cmd_error <= 1'b1;
            endcase
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_ADDR: begin
          addr <= addr_shift;
          if (cnt == CNT_W'(ADDR_NIBBLES - 1)) begin
            cnt <= '0;
            if (!is_read) begin
              state <= ST_WRITE;
            end else if (DUMMY_CYCLES > 0) begin
              state <= ST_DUMMY;
            end else begin
              data_out <= rd_data;
              data_dir <= 4'hF;
              state    <= ST_READ;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DUMMY: begin
          if (cnt == CNT_W'(DUMMY_CYCLES - 1)) begin
            cnt      <= '0;
            data_out <= rd_data;
            data_dir <= 4'hF;
            state    <= ST_READ;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_READ: begin
          addr     <= addr_inc;
          data_out <= rd_data;
        end
        ST_WRITE: begin
          addr <= addr_inc;
        end
        ST_IGNORE: begin
          state <= ST_IGNORE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_ram_responder.sv
// Directed bench for qspi_ram_responder: reset-enable/reset pairing, wrapped
// quad write and read, unknown command, aborted address and reset mid-write.
module tb_qspi_ram_responder;
  import qspi_pkg::*;

  logic       clk;
  logic       rst;
  logic       chip_enable;
  logic [3:0] data_in;
  logic [3:0] data_out;
  logic [3:0] data_dir;
  logic       soft_reset;
  logic       cmd_error;
  state_e     debug_state;

  int compared;
  int mismatched;

  qspi_ram_responder #(
    .DEPTH        (1024),
    .LEAD_CYCLES  (1),
    .DUMMY_CYCLES (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .chip_enable (chip_enable),
    .data_in     (data_in),
    .data_out    (data_out),
    .data_dir    (data_dir),
    .soft_reset  (soft_reset),
    .cmd_error   (cmd_error),
    .debug_state (debug_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, then observe 1 time unit after the rising edge.
  task automatic tick(input logic ce, input logic [3:0] d);
    @(negedge clk);
    chip_enable = ce;
    data_in     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic ce_high(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 4'h0);
  endtask

  task automatic start_cmd(input logic [7:0] b);
    tick(1'b0, 4'h0);
    for (int i = 7; i >= 0; i--) tick(1'b0, {3'b000, b[i]});
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) tick(1'b0, a[i*4 +: 4]);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    rst         = 1'b1;
    chip_enable = 1'b1;
    data_in     = 4'h0;
    tick(1'b1, 4'h0);
    tick(1'b1, 4'h0);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_data_dir", 32'(data_dir), 32'h0);
    check("rst_soft_reset", 32'(soft_reset), 32'h0);
    check("rst_cmd_error", 32'(cmd_error), 32'h0);
    check("rst_state", 32'(debug_state), 32'(ST_IDLE));
    rst = 1'b0;
    ce_high(2);

    // 0x66, CE high, 0x99 -> one pulse
    start_cmd(8'h66);
    check("en_state", 32'(debug_state), 32'(ST_IGNORE));
    check("en_no_pulse", 32'(soft_reset), 32'h0);
    ce_high(2);
    start_cmd(8'h99);
    check("rst_pulse", 32'(soft_reset), 32'h1);
    check("rst_no_err", 32'(cmd_error), 32'h0);
    tick(1'b0, 4'h0);
    check("rst_pulse_end", 32'(soft_reset), 32'h0);
    ce_high(2);

    // 0x99 alone, and 0x66 / 0x38 / 0x99 -> no pulse
    start_cmd(8'h99);
    check("lone_99", 32'(soft_reset), 32'h0);
    ce_high(2);
    start_cmd(8'h66);
    ce_high(2);
    start_cmd(8'h38);
    check("w_addr_state", 32'(debug_state), 32'(ST_ADDR));
    ce_high(2);
    start_cmd(8'h99);
    check("interrupted_99", 32'(soft_reset), 32'h0);
    check("interrupted_err", 32'(cmd_error), 32'h0);
    ce_high(2);

    // Wrapped write at 0x3FE: 1,2,3,4
    start_cmd(8'h38);
    send_addr(24'h0003FE);
    check("write_state", 32'(debug_state), 32'(ST_WRITE));
    tick(1'b0, 4'h1);
    tick(1'b0, 4'h2);
    tick(1'b0, 4'h3);
    tick(1'b0, 4'h4);
    check("write_dir", 32'(data_dir), 32'h0);
    ce_high(2);

    // Read back at 0x3FE after 6 dummy cycles
    start_cmd(8'hEB);
    send_addr(24'h0003FE);
    check("dummy_state", 32'(debug_state), 32'(ST_DUMMY));
    for (int i = 0; i < 5; i++) tick(1'b0, 4'h0);
    check("dummy_dir", 32'(data_dir), 32'h0);
    tick(1'b0, 4'h0);
    check("read_dir", 32'(data_dir), 32'hF);
    check("read_0", 32'(data_out), 32'h1);
    tick(1'b0, 4'h0);
    check("read_1", 32'(data_out), 32'h2);
    tick(1'b0, 4'h0);
    check("read_2_wrap", 32'(data_out), 32'h3);
    tick(1'b0, 4'h0);
    check("read_3", 32'(data_out), 32'h4);
    check("read_state", 32'(debug_state), 32'(ST_READ));
    ce_high(1);
    check("read_release", 32'(data_dir), 32'h0);
    ce_high(1);

    // Unknown command 0xA5
    start_cmd(8'hA5);
    check("bad_cmd_err", 32'(cmd_error), 32'h1);
    check("bad_cmd_no_rst", 32'(soft_reset), 32'h0);
    tick(1'b0, 4'hF);
    check("bad_cmd_err_end", 32'(cmd_error), 32'h0);
    for (int i = 0; i < 3; i++) tick(1'b0, 4'hF);
    check("bad_cmd_dir", 32'(data_dir), 32'h0);
    check("bad_cmd_state", 32'(debug_state), 32'(ST_IGNORE));
    ce_high(2);

    // Abort after 3 address nibbles, then read at 0
    start_cmd(8'hEB);
    tick(1'b0, 4'h0);
    tick(1'b0, 4'h0);
    tick(1'b0, 4'hF);
    ce_high(2);
    check("abort_state", 32'(debug_state), 32'(ST_IDLE));
    start_cmd(8'hEB);
    send_addr(24'h000000);
    for (int i = 0; i < 6; i++) tick(1'b0, 4'h0);
    check("abort_read_0", 32'(data_out), 32'h3);
    tick(1'b0, 4'h0);
    check("abort_read_1", 32'(data_out), 32'h4);
    ce_high(2);

    // Reset coincident with a write of 0xF at address 5
    start_cmd(8'h38);
    send_addr(24'h000004);
    tick(1'b0, 4'h6);
    tick(1'b0, 4'h7);
    ce_high(2);
    start_cmd(8'h38);
    send_addr(24'h000005);
    @(negedge clk);
    rst         = 1'b1;
    chip_enable = 1'b0;
    data_in     = 4'hF;
    @(posedge clk);
    #1;
    check("rst_write_dir", 32'(data_dir), 32'h0);
    check("rst_write_state", 32'(debug_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    ce_high(2);
    start_cmd(8'hEB);
    send_addr(24'h000004);
    for (int i = 0; i < 6; i++) tick(1'b0, 4'h0);
    check("keep_mem4", 32'(data_out), 32'h6);
    tick(1'b0, 4'h0);
    check("keep_mem5", 32'(data_out), 32'h7);
    ce_high(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/qspi_ram_responder.md
Name: qspi_ram_responder

Overview:
- Synthesizable responder for the QSPI RAM protocol issued by the team's VGA framebuffer initiator. It backs the initiator in FPGA prototypes and simulation benches.
- Decodes serial commands on data_in[0]: reset-enable 0x66, reset 0x99, quad write 0x38, quad read 0xEB.
- Serves an internal nibble-wide memory with auto-incrementing addresses.
- Same clock domain as the initiator: one transfer per clk edge while chip_enable is low; there is no separate SCK.

Parameters:
- DEPTH, 1024, number of 4-bit words; must be a power of two.
- ADDR_W, $clog2(DEPTH), internal address width; the 24-bit bus address is truncated to its low ADDR_W bits.
- LEAD_CYCLES, 1, low-CE edges ignored before the first command bit is sampled.
- DUMMY_CYCLES, 6, wait cycles between the address and read data.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- chip_enable  in  1  active-low chip select from the initiator.
- data_in  in  4  initiator-driven data lines.
- data_out  out  4  responder-driven data lines.
- data_dir  out  4  per-line drive enable: 1 = responder drives.
- soft_reset  out  1  one-cycle pulse when a valid 0x66/0x99 sequence completes.
- cmd_error  out  1  one-cycle pulse on an unknown command byte.

Behaviour:
- Reset (rst=1 at an edge) forces:
  - state IDLE, data_out=0, data_dir=0, soft_reset=0, cmd_error=0.
  - reset-enable latch cleared, bit and address counters cleared.
  - Memory contents are not cleared.
- Transfer cycle: a rising edge with chip_enable==0 and rst==0. chip_enable==1 at any edge forces IDLE and data_dir=0. This aborts any command: a partial address is discarded; nibbles already written stay written.
- States: IDLE, LEAD, CMD, ADDR, DUMMY, READ, WRITE, IGNORE.
- IDLE -> LEAD on the first transfer cycle. With LEAD_CYCLES=0, that cycle is instead command bit 7.
- LEAD: ignores LEAD_CYCLES transfer cycles in total, then -> CMD.
- CMD: samples 8 transfer cycles of data_in[0], MSB first. The other lines are don't-care. Decoded on the 8th edge:
  - 0x66: set the latch; -> IGNORE.
  - 0x99 with latch set: soft_reset=1 on the next cycle; clear the latch; -> IGNORE.
  - 0x99 with latch clear: clear the latch; -> IGNORE; no pulse.
  - 0x38 or 0xEB: clear the latch; -> ADDR, recording read/write.
  - Any other byte: cmd_error=1 on the next cycle; clear the latch; -> IGNORE.
- The latch survives CE deassertion between commands.
- ADDR: 6 transfer cycles, one data_in nibble each, most significant nibble first. Only the low ADDR_W bits are kept. Next state is DUMMY for a read with DUMMY_CYCLES>0, otherwise READ or WRITE.
- DUMMY: DUMMY_CYCLES transfer cycles, input ignored.
  - At the edge that ends the last dummy cycle (or the last address cycle when DUMMY_CYCLES=0): data_out <= mem[addr], data_dir <= 4'b1111, -> READ.
- READ: each transfer cycle does addr <= addr+1 (mod DEPTH) and data_out <= mem[addr+1]. The nibble for address A is therefore valid from the edge after the final wait cycle until the next transfer edge.
- WRITE: each transfer cycle does mem[addr] <= data_in and addr <= addr+1 (mod DEPTH). data_dir stays 0.
- IGNORE: holds until CE goes high; no memory access.
- Wrap-around: the address wraps from DEPTH-1 to 0 in both READ and WRITE.
- Simultaneous rst and transfer cycle: rst wins; no write occurs.
- soft_reset does not clear memory; it only pulses and clears the latch.

Decomposition:
- Shared package qspi_pkg:
  - Command opcodes: CMD_RESET_EN=8'h66, CMD_RESET=8'h99, CMD_WRITE_QUAD=8'h38, CMD_READ_QUAD=8'hEB.
  - ADDR_NIBBLES=6.
  - State encoding constants, shared with the initiator's state machine.
- One natural sub-module, qspi_nibble_mem: DEPTH x 4 array with a synchronous write port and an asynchronous read port. It maps to distributed RAM.
- The command FSM and counters stay in qspi_ram_responder.

Test Plan:
- Initiator sequence 0x66, CE high 2 cycles, 0x99 (LEAD_CYCLES=1) -> one soft_reset pulse exactly one cycle after the 8th bit of 0x99; cmd_error never asserts.
- 0x99 alone, and 0x66 then 0x38 (CE toggled) then 0x99 -> no soft_reset pulse.
- Write 0x38 at address 0x0003FE with nibbles 1,2,3,4, DEPTH=1024 -> mem[1022]=1, mem[1023]=2, mem[0]=3, mem[1]=4 (wrap). Then read 0xEB at 0x0003FE -> after 6 dummy cycles, data_dir=1111 and data_out sequence 1,2,3,4.
- Command byte 0xA5 -> cmd_error pulse one cycle after the 8th bit; data_dir stays 0 and memory is unchanged while 4 more nibbles are clocked.
- CE deasserted after 3 address nibbles, then a new 0xEB read at 0 -> first nibble equals mem[0], so the aborted address had no effect.
- rst asserted during WRITE, coincident with a nibble 0xF at addr 5 -> mem[5] unchanged; next edge data_dir=0 and state IDLE; a following read sees the prior contents.
